// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module : multicycle_pkg
// Brief  : States, opcodes, control-field codes and instruction classes.
// Rev    : 1.0
// ============================================================================
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_WB_ALU   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;

  localparam logic [6:0] c_F7_SUB    = 7'b0100000;

  localparam logic [2:0] c_ALU_ADD   = 3'b000;
  localparam logic [2:0] c_ALU_SUB   = 3'b001;
  localparam logic [2:0] c_ALU_PASSB = 3'b010;

  localparam logic [2:0] c_IMM_I     = 3'd0;
  localparam logic [2:0] c_IMM_B     = 3'd1;
  localparam logic [2:0] c_IMM_S     = 3'd2;
  localparam logic [2:0] c_IMM_J     = 3'd3;
  localparam logic [2:0] c_IMM_U     = 3'd4;

  localparam logic [1:0] c_PC_PLUS4  = 2'b00;
  localparam logic [1:0] c_PC_TARGET = 2'b01;
  localparam logic [1:0] c_PC_ALU    = 2'b10;

  localparam logic [1:0] c_RES_ALU   = 2'b00;
  localparam logic [1:0] c_RES_MEM   = 2'b01;
  localparam logic [1:0] c_RES_PC4   = 2'b10;

  localparam logic [1:0] c_TRAP_NONE    = 2'd0;
  localparam logic [1:0] c_TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] c_TRAP_TIMEOUT = 2'd2;

  typedef struct packed {
    logic alu_r;
    logic alu_i;
    logic lui;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic illegal;
  } instr_class_t;

  // Only beq/bne are supported; any other funct3 on a branch traps.
  function automatic logic branch_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001);
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
    return ((f3 == 3'b000) && zero) || ((f3 == 3'b001) && !zero);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module : multicycle_control_if
// Brief  : Instruction fields in, datapath control strobes and status out.
// Rev    : 1.0
// ============================================================================
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             Zero;
  logic             mem_ready;

  logic             PCWrite;
  logic             IRWrite;
  logic             AdrSrc;
  logic             MemRead;
  logic             MemWrite;
  logic [2:0]       MemSrc;
  logic [1:0]       PCSrc;
  logic [2:0]       ALUControl;
  logic             ALUSrcB;
  logic [2:0]       ImmSrc;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic             instr_done;
  logic [CNT_W-1:0] retired;
  logic             trap;
  logic [1:0]       trap_cause;

  modport master (
    input  op, funct3, funct7, Zero, mem_ready,
    output PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, MemSrc, PCSrc,
           ALUControl, ALUSrcB, ImmSrc, RegWrite, ResultSrc,
           instr_done, retired, trap, trap_cause
  );

  modport slave (
    output op, funct3, funct7, Zero, mem_ready,
    input  PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, MemSrc, PCSrc,
           ALUControl, ALUSrcB, ImmSrc, RegWrite, ResultSrc,
           instr_done, retired, trap, trap_cause
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_decode.sv
`default_nettype none
// ============================================================================
// Module : instr_class_decode
// Brief  : Maps the opcode to a one-hot instruction class.
// Rev    : 1.0
// ============================================================================
module instr_class_decode
  import multicycle_pkg::*;
(
  input  wire logic [6:0]   i_op,
  output instr_class_t      o_class
);

  always_comb begin
    o_class = '0;
    case (i_op)
      c_OP_R:      o_class.alu_r   = 1'b1;
      c_OP_I:      o_class.alu_i   = 1'b1;
      c_OP_LUI:    o_class.lui     = 1'b1;
      c_OP_LOAD:   o_class.load    = 1'b1;
      c_OP_STORE:  o_class.store   = 1'b1;
      c_OP_BRANCH: o_class.branch  = 1'b1;
      c_OP_JAL:    o_class.jal     = 1'b1;
      c_OP_JALR:   o_class.jalr    = 1'b1;
      default:     o_class.illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module : multicycle_control
// Brief  : Multi-cycle RV32I-subset control FSM with shared memory port,
//          memory timeout / illegal-opcode trap and retired-instruction count.
// Rev    : 1.0
// ============================================================================
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  multicycle_control_if.master bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]    r_retired;
  logic                r_trap;
  logic [1:0]          r_cause;

  state_t              w_next_state;
  logic [1:0]          w_next_cause;
  instr_class_t        w_cls;
  logic                w_timeout_hit;
  logic                w_timeout;
  logic                w_wait_state;
  logic                w_retire;
  logic                w_br_legal;
  logic                w_taken;

  logic                w_pcwrite, w_irwrite, w_adrsrc, w_memread, w_memwrite;
  logic                w_alusrcb, w_regwrite;
  logic [1:0]          w_pcsrc, w_resultsrc;
  logic [2:0]          w_aluctl, w_immsrc;

  instr_class_decode u_decode (
    .i_op    (bus.op),
    .o_class (w_cls)
  );

  if (MEM_TIMEOUT > 0) begin : g_timeout
    assign w_timeout_hit = (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  end else begin : g_no_timeout
    assign w_timeout_hit = 1'b0;
  end

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                        (r_state == S_MEM_WR);
  // A ready in the final allowed wait cycle still completes the access.
  assign w_timeout    = w_timeout_hit && !bus.mem_ready;
  assign w_br_legal   = branch_legal(bus.funct3);
  assign w_taken      = branch_taken(bus.funct3, bus.Zero);

  assign w_retire = (r_state == S_WB_ALU) || (r_state == S_WB_MEM) ||
                    (r_state == S_JUMP) ||
                    ((r_state == S_BRANCH) && w_br_legal) ||
                    ((r_state == S_MEM_WR) && bus.mem_ready);

  always_comb begin
    w_next_state = r_state;
    w_next_cause = c_TRAP_ILLEGAL;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready) begin
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_next_state = S_TRAP;
          w_next_cause = c_TRAP_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (w_cls.alu_r || w_cls.alu_i || w_cls.lui) w_next_state = S_EXEC;
        else if (w_cls.load || w_cls.store)          w_next_state = S_MEM_ADDR;
        else if (w_cls.branch)                       w_next_state = S_BRANCH;
        else if (w_cls.jal || w_cls.jalr)            w_next_state = S_JUMP;
        else                                         w_next_state = S_TRAP;
      end
      S_EXEC:     w_next_state = S_WB_ALU;
      S_MEM_ADDR: w_next_state = w_cls.load ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD, S_MEM_WR: begin
        if (bus.mem_ready) begin
          w_next_state = (r_state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end else if (w_timeout) begin
          w_next_state = S_TRAP;
          w_next_cause = c_TRAP_TIMEOUT;
        end
      end
      S_WB_ALU, S_WB_MEM, S_JUMP: w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = w_br_legal ? S_FETCH : S_TRAP;
      S_TRAP:     w_next_state = S_TRAP;
      default:    w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_retired  <= '0;
      r_trap     <= 1'b0;
      r_cause    <= c_TRAP_NONE;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_wait_state && !bus.mem_ready) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      if ((w_next_state == S_TRAP) && (r_state != S_TRAP)) begin
        r_trap  <= 1'b1;
        r_cause <= w_next_cause;
      end
    end
  end

  always_comb begin
    w_pcwrite   = 1'b0;
    w_irwrite   = 1'b0;
    w_adrsrc    = 1'b0;
    w_memread   = 1'b0;
    w_memwrite  = 1'b0;
    w_alusrcb   = 1'b0;
    w_regwrite  = 1'b0;
    w_pcsrc     = c_PC_PLUS4;
    w_resultsrc = c_RES_ALU;
    w_aluctl    = c_ALU_ADD;
    w_immsrc    = c_IMM_I;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          w_memread = 1'b1;
          w_irwrite = bus.mem_ready;
          w_pcwrite = bus.mem_ready;
        end
        S_EXEC: begin
          w_alusrcb = !w_cls.alu_r;
          if (w_cls.lui)                                   w_aluctl = c_ALU_PASSB;
          else if (w_cls.alu_r && bus.funct7 == c_F7_SUB)  w_aluctl = c_ALU_SUB;
          w_immsrc  = w_cls.lui ? c_IMM_U : c_IMM_I;
        end
        S_MEM_ADDR: begin
          w_alusrcb = 1'b1;
          w_immsrc  = w_cls.store ? c_IMM_S : c_IMM_I;
        end
        S_MEM_RD: begin
          w_adrsrc  = 1'b1;
          w_memread = 1'b1;
        end
        S_MEM_WR: begin
          w_adrsrc   = 1'b1;
          w_memwrite = 1'b1;
        end
        S_WB_ALU: begin
          w_regwrite  = 1'b1;
          w_resultsrc = c_RES_ALU;
        end
        S_WB_MEM: begin
          w_regwrite  = 1'b1;
          w_resultsrc = c_RES_MEM;
        end
        S_BRANCH: begin
          w_aluctl = c_ALU_SUB;
          w_immsrc = c_IMM_B;
          w_pcsrc  = c_PC_TARGET;
          w_pcwrite = w_taken;
        end
        S_JUMP: begin
          w_pcwrite   = 1'b1;
          w_regwrite  = 1'b1;
          w_resultsrc = c_RES_PC4;
          if (w_cls.jalr) begin
            w_pcsrc   = c_PC_ALU;
            w_alusrcb = 1'b1;
            w_immsrc  = c_IMM_I;
          end else begin
            w_pcsrc   = c_PC_TARGET;
            w_immsrc  = c_IMM_J;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.PCWrite    = w_pcwrite;
  assign bus.IRWrite    = w_irwrite;
  assign bus.AdrSrc     = w_adrsrc;
  assign bus.MemRead    = w_memread;
  assign bus.MemWrite   = w_memwrite;
  assign bus.MemSrc     = rst ? 3'b000 : bus.funct3;
  assign bus.PCSrc      = w_pcsrc;
  assign bus.ALUControl = w_aluctl;
  assign bus.ALUSrcB    = w_alusrcb;
  assign bus.ImmSrc     = w_immsrc;
  assign bus.RegWrite   = w_regwrite;
  assign bus.ResultSrc  = w_resultsrc;
  assign bus.instr_done = w_retire && !rst;
  assign bus.retired    = rst ? '0 : r_retired;
  assign bus.trap       = r_trap && !rst;
  assign bus.trap_cause = rst ? c_TRAP_NONE : r_cause;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module : tb_multicycle_control
// Brief  : Table vectors, hand sequences and random instructions checked
//          against a cycle-count / event-count model of the control unit.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam int TO    = 4;
  localparam int BOUND = 40;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_ST   = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BAD  = 7'b0001111;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic zero; int sf; int sm;
  } stim_t;

  typedef struct {
    int cycles; int done_cnt; int regwr_cnt; int regwr_last; int pcwr_cnt;
    int pcsrc_last; int res_last; int alu3; int srcb3; int imm3;
    int adr1_cnt; int trap; int cause;
  } res_t;

  typedef struct { stim_t s; res_t e; } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_retired = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) bus ();

  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic z, input int sf, input int sm,
      input int cyc, input int dn, input int rwc, input int rwl, input int pwc,
      input int pcs, input int res, input int alu, input int sb, input int imm,
      input int adr, input int tr, input int cs);
    vec_t v;
    v.s = '{op, f3, f7, z, sf, sm};
    v.e = '{cyc, dn, rwc, rwl, pwc, pcs, res, alu, sb, imm, adr, tr, cs};
    tbl.push_back(v);
  endfunction

  // Expected behaviour from instruction class, latency rules and stalls.
  function automatic res_t model(input stim_t s);
    res_t r;
    int   t;
    r = '{default: 0};
    if (s.sf >= TO) begin
      r.cycles = TO + 1; r.trap = 1; r.cause = 2;
      return r;
    end
    t = s.sf + 2;
    r.pcwr_cnt = 1;
    if (s.op == OPC_R || s.op == OPC_I || s.op == OPC_LUI) begin
      r.cycles = t + 2; r.done_cnt = 1; r.regwr_cnt = 1; r.regwr_last = 1;
      r.alu3  = (s.op == OPC_LUI) ? 2 : ((s.op == OPC_R && s.f7 == 7'b0100000) ? 1 : 0);
      r.srcb3 = (s.op == OPC_R) ? 0 : 1;
      r.imm3  = (s.op == OPC_LUI) ? 4 : 0;
    end else if (s.op == OPC_LD || s.op == OPC_ST) begin
      r.srcb3 = 1; r.imm3 = (s.op == OPC_ST) ? 2 : 0;
      if (s.sm >= TO) begin
        r.cycles = t + TO + 2; r.adr1_cnt = TO; r.trap = 1; r.cause = 2;
      end else begin
        r.adr1_cnt = s.sm + 1; r.done_cnt = 1;
        if (s.op == OPC_LD) begin
          r.cycles = t + s.sm + 3; r.regwr_cnt = 1; r.regwr_last = 1; r.res_last = 1;
        end else begin
          r.cycles = t + s.sm + 2;
        end
      end
    end else if (s.op == OPC_BR) begin
      r.alu3 = 1; r.imm3 = 1;
      if (s.f3 == 3'd0 || s.f3 == 3'd1) begin
        r.cycles = t + 1; r.done_cnt = 1; r.pcsrc_last = 1;
        r.pcwr_cnt += ((s.f3 == 3'd0) ? s.zero : !s.zero) ? 1 : 0;
      end else begin
        r.cycles = t + 2; r.trap = 1; r.cause = 1;
      end
    end else if (s.op == OPC_JAL || s.op == OPC_JALR) begin
      r.cycles = t + 1; r.done_cnt = 1; r.regwr_cnt = 1; r.regwr_last = 1;
      r.pcwr_cnt = 2; r.res_last = 2;
      r.pcsrc_last = (s.op == OPC_JAL) ? 1 : 2;
      r.srcb3 = (s.op == OPC_JAL) ? 0 : 1;
      r.imm3  = (s.op == OPC_JAL) ? 3 : 0;
    end else begin
      r.cycles = t + 1; r.trap = 1; r.cause = 1;
    end
    return r;
  endfunction

  // Starts and ends on a falling edge; the memory stalls each access by
  // the requested number of cycles, and drives random ready otherwise.
  task automatic run(input stim_t s, output res_t o);
    bit prev_req = 1'b0;
    bit req;
    bit ended = 1'b0;
    int acc = 0;
    int acc_cnt = 0;
    int stalls[2];
    o = '{default: 0};
    stalls[0] = s.sf;
    stalls[1] = s.sm;
    bus.op = s.op; bus.funct3 = s.f3; bus.funct7 = s.f7; bus.Zero = s.zero;
    for (int cyc = 1; cyc <= BOUND; cyc++) begin
      req = bus.MemRead | bus.MemWrite;
      if (req && !prev_req) begin acc++; acc_cnt = 0; end
      if (req) begin
        bus.mem_ready = (acc >= 1 && acc <= 2) ? (acc_cnt >= stalls[acc-1]) : 1'b1;
        acc_cnt++;
      end else begin
        bus.mem_ready = 1'($urandom);
      end
      prev_req = req;
      #1;
      o.cycles = cyc;
      if (cyc == s.sf + 3) begin
        o.alu3 = int'(bus.ALUControl); o.srcb3 = int'(bus.ALUSrcB); o.imm3 = int'(bus.ImmSrc);
      end
      if (bus.RegWrite)   o.regwr_cnt++;
      if (bus.PCWrite)    o.pcwr_cnt++;
      if (bus.instr_done) o.done_cnt++;
      if ((bus.MemRead || bus.MemWrite) && bus.AdrSrc) o.adr1_cnt++;
      o.regwr_last = int'(bus.RegWrite);
      o.pcsrc_last = int'(bus.PCSrc);
      o.res_last   = int'(bus.ResultSrc);
      o.trap       = int'(bus.trap);
      o.cause      = int'(bus.trap_cause);
      if (bus.instr_done || bus.trap) begin ended = 1'b1; break; end
      @(posedge clk); @(negedge clk);
    end
    if (!ended) chk("cycle_budget", 0, 1);
    if (bus.instr_done) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_outputs_zero", int'({bus.PCWrite, bus.IRWrite, bus.AdrSrc, bus.MemRead,
        bus.MemWrite, bus.MemSrc, bus.PCSrc, bus.ALUControl, bus.ALUSrcB, bus.ImmSrc,
        bus.RegWrite, bus.ResultSrc, bus.instr_done, bus.trap, bus.trap_cause} != 0), 0);
    @(posedge clk); @(negedge clk);
    chk("rst_retired", int'(bus.retired), 0);
    rst = 1'b0;
    exp_retired = 0;
    #1;
    chk("post_rst_fetch_memread", int'(bus.MemRead), 1);
    chk("post_rst_trap", int'({bus.trap, bus.trap_cause}), 0);
  endtask

  task automatic trap_hold(input int cause);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      bus.mem_ready = 1'($urandom);
      #1;
      chk("trap_sticky", int'(bus.trap), 1);
      chk("trap_cause_hold", int'(bus.trap_cause), cause);
      chk("trap_quiet", int'({bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite,
                              bus.RegWrite, bus.instr_done}), 0);
    end
    chk("trap_retired_kept", int'(bus.retired), exp_retired);
  endtask

  task automatic apply(input stim_t s, input res_t e, input string tag);
    res_t o;
    run(s, o);
    chk({tag, " cycles"},     o.cycles,     e.cycles);
    chk({tag, " instr_done"}, o.done_cnt,   e.done_cnt);
    chk({tag, " regwr_cnt"},  o.regwr_cnt,  e.regwr_cnt);
    chk({tag, " regwr_last"}, o.regwr_last, e.regwr_last);
    chk({tag, " pcwr_cnt"},   o.pcwr_cnt,   e.pcwr_cnt);
    chk({tag, " pcsrc_last"}, o.pcsrc_last, e.pcsrc_last);
    chk({tag, " res_last"},   o.res_last,   e.res_last);
    chk({tag, " aluctl"},     o.alu3,       e.alu3);
    chk({tag, " alusrcb"},    o.srcb3,      e.srcb3);
    chk({tag, " immsrc"},     o.imm3,       e.imm3);
    chk({tag, " adr1_cnt"},   o.adr1_cnt,   e.adr1_cnt);
    chk({tag, " trap"},       o.trap,       e.trap);
    chk({tag, " cause"},      o.cause,      e.cause);
    if (e.trap != 0) trap_hold(e.cause);
    if (e.trap != 0 || o.trap != 0) begin
      do_reset();
    end else begin
      exp_retired++;
      chk({tag, " retired"}, int'(bus.retired), exp_retired);
    end
  endtask

  function automatic int pick_stall();
    int r = int'($urandom_range(0, 19));
    return (r < 16) ? (r % 3) : ((r < 18) ? 3 : 4);
  endfunction

  function automatic stim_t rand_stim();
    stim_t      s;
    logic [6:0] ops[10] = '{OPC_R, OPC_I, OPC_LUI, OPC_LD, OPC_ST, OPC_BR,
                            OPC_JAL, OPC_JALR, OPC_BAD, 7'b1110011};
    s.op   = ops[$urandom_range(0, 9)];
    s.f3   = 3'($urandom);
    if (s.op == OPC_BR && $urandom_range(0, 3) != 0) s.f3 = 3'($urandom_range(0, 1));
    s.f7   = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'($urandom);
    s.zero = 1'($urandom);
    s.sf   = pick_stall();
    s.sm   = pick_stall();
    return s;
  endfunction

  initial begin
    stim_t s;
    res_t  o;
    rst = 1'b1;
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7 = 7'd0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;

    //      op        f3   f7          z  sf sm  cyc dn rwc rwl pwc pcs res alu sb imm adr tr cs
    add_vec(OPC_I,    0, 7'b0000000, 0, 0, 0,  4, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add_vec(OPC_R,    0, 7'b0000000, 0, 0, 0,  4, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(OPC_R,    0, 7'b0100000, 0, 0, 0,  4, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    add_vec(OPC_I,    0, 7'b0100000, 0, 0, 0,  4, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add_vec(OPC_LUI,  0, 7'b0000000, 0, 0, 0,  4, 1, 1, 1, 1, 0, 0, 2, 1, 4, 0, 0, 0);
    add_vec(OPC_LD,   2, 7'b0000000, 0, 0, 0,  5, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0);
    add_vec(OPC_LD,   4, 7'b0000000, 0, 0, 3,  8, 1, 1, 1, 1, 0, 1, 0, 1, 0, 4, 0, 0);
    add_vec(OPC_ST,   2, 7'b0000000, 0, 0, 0,  4, 1, 0, 0, 1, 0, 0, 0, 1, 2, 1, 0, 0);
    add_vec(OPC_ST,   2, 7'b0000000, 0, 0, 3,  7, 1, 0, 0, 1, 0, 0, 0, 1, 2, 4, 0, 0);
    add_vec(OPC_BR,   0, 7'b0000000, 1, 0, 0,  3, 1, 0, 0, 2, 1, 0, 1, 0, 1, 0, 0, 0);
    add_vec(OPC_BR,   0, 7'b0000000, 0, 0, 0,  3, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    add_vec(OPC_BR,   1, 7'b0000000, 0, 0, 0,  3, 1, 0, 0, 2, 1, 0, 1, 0, 1, 0, 0, 0);
    add_vec(OPC_BR,   1, 7'b0000000, 1, 0, 0,  3, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    add_vec(OPC_JAL,  0, 7'b0000000, 0, 0, 0,  3, 1, 1, 1, 2, 1, 2, 0, 0, 3, 0, 0, 0);
    add_vec(OPC_JALR, 0, 7'b0000000, 0, 0, 0,  3, 1, 1, 1, 2, 2, 2, 0, 1, 0, 0, 0, 0);
    add_vec(OPC_I,    0, 7'b0000000, 0, 3, 0,  7, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add_vec(OPC_BAD,  0, 7'b0000000, 0, 0, 0,  3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    add_vec(OPC_BR,   2, 7'b0000000, 0, 0, 0,  4, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 1);
    add_vec(OPC_I,    0, 7'b0000000, 0, 4, 0,  5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    add_vec(OPC_LD,   2, 7'b0000000, 0, 0, 4,  8, 0, 0, 0, 1, 0, 0, 0, 1, 0, 4, 1, 2);

    do_reset();
    foreach (tbl[i]) apply(tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));

    // Reset while a load waits for memory: the load is abandoned and the
    // following instruction starts cleanly from FETCH.
    bus.op = OPC_LD; bus.funct3 = 3'd2; bus.funct7 = 7'd0; bus.Zero = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.mem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1;
    chk("midrst_in_mem_rd", int'({bus.MemRead, bus.AdrSrc}), 3);
    do_reset();
    s = '{OPC_I, 3'd0, 7'd0, 1'b0, 0, 0};
    run(s, o);
    chk("midrst_next_cycles", o.cycles, 4);
    chk("midrst_next_retired", int'(bus.retired), 1);
    exp_retired = 1;

    for (int i = 0; i < 150; i++) begin
      s = rand_stim();
      apply(s, model(s), $sformatf("rnd%0d op=%b f3=%0d", i, s.op, s.f3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
